// File: rtl/sound_ram_arb.sv
// sound_ram_arb: arbiter for the single-port 64 KB sound RAM (syncram with a
// one-cycle registered read). It is shared by the DOC sample-fetch path and
// the host (soundglu SNDDATA) path. DOC has fixed priority. A bounded-wait
// counter forces a host grant after HOST_MAX_WAIT lost arbitrations.
//
// Ports:
//   CLK_14M, reset_n         clock, asynchronous active-low reset
//   doc_req/doc_addr         DOC fetch request (level, held until doc_ack)
//   doc_ack/doc_data         DOC completion pulse and read data
//   host_req/host_wr/host_addr/host_wdata   host request (level, held until host_ack)
//   host_ack/host_rdata      host completion pulse and read data
//   ram_addr/ram_we/ram_wdata/ram_rdata     syncram port
//   busy                     high while an access is in flight
//
// Optional build macro SOUND_ARB_STATS_EN adds stat_clr, stat_doc, stat_host
// and stat_forced (completed DOC / host accesses and forced host grants).

module sound_ram_arb #(
  parameter int unsigned HOST_MAX_WAIT = 8,
  parameter int unsigned WAIT_W        = 4
) (
  input  logic        CLK_14M,
  input  logic        reset_n,
  input  logic        doc_req,
  input  logic [15:0] doc_addr,
  output logic        doc_ack,
  output logic [7:0]  doc_data,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        busy
`ifdef SOUND_ARB_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_doc,
  output logic [15:0] stat_host,
  output logic [7:0]  stat_forced
`endif
);

  localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(HOST_MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACC_DOC   = 3'd1,
    ACC_HOST  = 3'd2,
    DONE_DOC  = 3'd3,
    DONE_HOST = 3'd4
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              host_is_wr;
  logic [7:0]        doc_data_q;
  logic [7:0]        host_rdata_q;

  logic grant_doc_c;
  logic grant_host_c;
  logic forced_c;

  // Grant decision, evaluated only in IDLE; a starved host overrides DOC priority.
  always_comb begin
    grant_doc_c  = 1'b0;
    grant_host_c = 1'b0;
    forced_c     = 1'b0;
    if (state == IDLE) begin
      if (host_req && (wait_cnt >= MAX_WAIT)) begin
        grant_host_c = 1'b1;
        forced_c     = 1'b1;
      end else if (doc_req) begin
        grant_doc_c  = 1'b1;
      end else if (host_req) begin
        grant_host_c = 1'b1;
      end
    end
  end

  // State machine with registered RAM port; the RAM port is only live in ACC_*.
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ram_addr     <= '0;
      ram_we       <= 1'b0;
      ram_wdata    <= '0;
      busy         <= 1'b0;
      wait_cnt     <= '0;
      host_is_wr   <= 1'b0;
      doc_data_q   <= '0;
      host_rdata_q <= '0;
    end else begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;

      if (grant_host_c || !host_req) begin
        wait_cnt <= '0;
      end else if (grant_doc_c && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_host_c) begin
            state      <= ACC_HOST;
            ram_addr   <= host_addr;
            ram_we     <= host_wr;
            ram_wdata  <= host_wdata;
            host_is_wr <= host_wr;
            busy       <= 1'b1;
          end else if (grant_doc_c) begin
            state    <= ACC_DOC;
            ram_addr <= doc_addr;
            busy     <= 1'b1;
          end
        end
        ACC_DOC:  state <= DONE_DOC;
        ACC_HOST: state <= DONE_HOST;
        DONE_DOC: begin
          doc_data_q <= ram_rdata;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        DONE_HOST: begin
          if (!host_is_wr) host_rdata_q <= ram_rdata;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign doc_ack  = (state == DONE_DOC);
  assign host_ack = (state == DONE_HOST);

  // Read data is valid during the ack cycle: pass the RAM output through while
  // in DONE_*, then hold the captured copy until the next completion.
  assign doc_data   = (state == DONE_DOC) ? ram_rdata : doc_data_q;
  assign host_rdata = ((state == DONE_HOST) && !host_is_wr) ? ram_rdata : host_rdata_q;

`ifdef SOUND_ARB_STATS_EN
  // Wrapping activity counters; a clear takes precedence over a same-cycle count.
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      stat_doc    <= '0;
      stat_host   <= '0;
      stat_forced <= '0;
    end else if (stat_clr) begin
      stat_doc    <= '0;
      stat_host   <= '0;
      stat_forced <= '0;
    end else begin
      if (state == DONE_DOC)  stat_doc    <= stat_doc + 16'd1;
      if (state == DONE_HOST) stat_host   <= stat_host + 16'd1;
      if (forced_c)           stat_forced <= stat_forced + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sound_ram_arb.sv
// Testbench for sound_ram_arb: behavioural syncram, DOC and host requester
// agents fed from command queues, and an ack monitor popping a scoreboard of
// expected completions (source and data) in order.

module tb_sound_ram_arb;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } hcmd_t;

  typedef struct {
    logic       is_doc;
    logic [7:0] data;
  } exp_t;

  logic        CLK_14M;
  logic        reset_n;
  logic        doc_req;
  logic [15:0] doc_addr;
  logic        doc_ack;
  logic [7:0]  doc_data;
  logic        host_req;
  logic        host_wr;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        busy;
`ifdef SOUND_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_doc;
  logic [15:0] stat_host;
  logic [7:0]  stat_forced;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] doc_q[$];
  hcmd_t       host_q[$];
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  mem [0:65535];

  sound_ram_arb #(.HOST_MAX_WAIT(8), .WAIT_W(4)) dut (
    .CLK_14M    (CLK_14M),
    .reset_n    (reset_n),
    .doc_req    (doc_req),
    .doc_addr   (doc_addr),
    .doc_ack    (doc_ack),
    .doc_data   (doc_data),
    .host_req   (host_req),
    .host_wr    (host_wr),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy       (busy)
`ifdef SOUND_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_doc    (stat_doc),
    .stat_host   (stat_host),
    .stat_forced (stat_forced)
`endif
  );

  initial CLK_14M = 1'b0;
  always #5 CLK_14M = ~CLK_14M;

  // Syncram model: registered read of the old contents, then write.
  always @(posedge CLK_14M) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // DOC requester: holds req until ack, then advances to the next queued address or drops.
  initial begin : doc_agent
    int wait_n;
    wait_n   = 0;
    doc_req  = 1'b0;
    doc_addr = '0;
    forever begin
      @(negedge CLK_14M);
      if (doc_req) begin
        if (doc_ack) begin
          wait_n = 0;
          if (doc_q.size() > 0) doc_addr = doc_q.pop_front();
          else doc_req = 1'b0;
        end else if (++wait_n > 300) begin
          checks++;
          failures++;
          $display("FAIL doc_ack_timeout actual=none required=ack addr=%0h", doc_addr);
          doc_req = 1'b0;
          wait_n  = 0;
        end
      end else if (doc_q.size() > 0) begin
        doc_addr = doc_q.pop_front();
        doc_req  = 1'b1;
      end
    end
  end

  // Host requester: same handshake discipline as the DOC agent.
  initial begin : host_agent
    int    wait_n;
    hcmd_t c;
    wait_n     = 0;
    host_req   = 1'b0;
    host_wr    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    forever begin
      @(negedge CLK_14M);
      if (host_req) begin
        if (host_ack) begin
          wait_n = 0;
          if (host_q.size() > 0) begin
            c = host_q.pop_front();
            host_wr = c.wr; host_addr = c.addr; host_wdata = c.wdata;
          end else begin
            host_req = 1'b0;
          end
        end else if (++wait_n > 300) begin
          checks++;
          failures++;
          $display("FAIL host_ack_timeout actual=none required=ack addr=%0h", host_addr);
          host_req = 1'b0;
          wait_n   = 0;
        end
      end else if (host_q.size() > 0) begin
        c = host_q.pop_front();
        host_wr = c.wr; host_addr = c.addr; host_wdata = c.wdata;
        host_req = 1'b1;
      end
    end
  end

  // Ack monitor: every completion must match the next scoreboard entry.
  always @(negedge CLK_14M) begin
    if (reset_n && (doc_ack || host_ack)) begin
      check("dual_ack", 32'(doc_ack & host_ack), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=doc%0b_host%0b required=none", doc_ack, host_ack);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_source_is_doc", 32'(doc_ack), 32'(mon_e.is_doc));
        check("ack_data", 32'(doc_ack ? doc_data : host_rdata), 32'(mon_e.data));
      end
    end
  end

  task automatic push_exp(input logic is_doc, input logic [7:0] data);
    exp_t e;
    e.is_doc = is_doc;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  task automatic push_host(input logic wr, input logic [15:0] addr, input logic [7:0] wdata);
    hcmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata;
    host_q.push_back(c);
  endtask

  // Wait (bounded) for all queued traffic to complete, then step off the edge.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || doc_q.size() != 0 || host_q.size() != 0 ||
            doc_req || host_req) && n < 1000) begin
      @(negedge CLK_14M);
      n++;
    end
    repeat (2) @(negedge CLK_14M);
    check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    reset_n = 1'b0;
`ifdef SOUND_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;
    mem[16'h2222] = 8'h11;
    for (int i = 0; i < 18; i++) mem[16'h1000 + i] = 8'(8'h30 + i);

    // Reset with both requests pending: everything quiet, then DOC wins first.
    doc_q.push_back(16'h1234);
    push_host(1'b1, 16'hBEEF, 8'h5A);
    push_exp(1'b1, 8'hA5);
    push_exp(1'b0, 8'h00);
    repeat (4) begin
      @(negedge CLK_14M);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_busy_acks", 32'({busy, doc_ack, host_ack}), 32'd0);
      check("rst_data", 32'({doc_data, host_rdata, ram_wdata}), 32'd0);
    end
    check("rst_reqs_pending", 32'({doc_req, host_req}), 32'b11);
    reset_n = 1'b1;
    @(negedge CLK_14M);
    check("first_grant_addr", 32'(ram_addr), 32'h1234);
    check("first_grant_we", 32'(ram_we), 32'd0);
    check("first_grant_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge CLK_14M);
    check("host_wr_we", 32'(ram_we), 32'd1);
    check("host_wr_addr", 32'(ram_addr), 32'hBEEF);
    check("host_wr_wdata", 32'(ram_wdata), 32'h5A);
    @(negedge CLK_14M);
    check("host_wr_we_one_cycle", 32'(ram_we), 32'd0);
    drain("reset_phase");

    // Host read-back of the write, then a DOC read of the same location.
    push_host(1'b0, 16'hBEEF, 8'h00);
    push_exp(1'b0, 8'h5A);
    drain("host_read");
    check("host_rdata_hold", 32'(host_rdata), 32'h5A);
    doc_q.push_back(16'hBEEF);
    push_exp(1'b1, 8'h5A);
    drain("doc_read");
    check("doc_data_hold", 32'(doc_data), 32'h5A);
    check("host_rdata_after_doc", 32'(host_rdata), 32'h5A);

`ifdef SOUND_ARB_STATS_EN
    stat_clr = 1'b1;
    @(negedge CLK_14M);
    stat_clr = 1'b0;
    #1;
`endif

    // Contention: 8 DOC grants, forced host, 8 DOC, forced host, 2 DOC.
    for (int i = 0; i < 18; i++) doc_q.push_back(16'h1000 + 16'(i));
    push_host(1'b0, 16'hBEEF, 8'h00);
    push_host(1'b0, 16'h1234, 8'h00);
    for (int i = 0; i < 8; i++) push_exp(1'b1, 8'(8'h30 + i));
    push_exp(1'b0, 8'h5A);
    for (int i = 8; i < 16; i++) push_exp(1'b1, 8'(8'h30 + i));
    push_exp(1'b0, 8'hA5);
    push_exp(1'b1, 8'h40);
    push_exp(1'b1, 8'h41);
    drain("contention");

`ifdef SOUND_ARB_STATS_EN
    check("stat_doc", 32'(stat_doc), 32'd18);
    check("stat_host", 32'(stat_host), 32'd2);
    check("stat_forced", 32'(stat_forced), 32'd2);
    stat_clr = 1'b1;
    @(negedge CLK_14M);
    stat_clr = 1'b0;
    @(negedge CLK_14M);
    check("stat_clr_all", 32'({stat_doc, stat_host}) | 32'(stat_forced), 32'd0);
    #1;
`endif

    // Reset during ACC_HOST of a write: abort, no ack, then re-arbitrated.
    push_host(1'b1, 16'h2222, 8'h99);
    push_exp(1'b0, 8'h00);
    n = 0;
    do begin
      @(negedge CLK_14M);
      n++;
    end while (!ram_we && n < 50);
    check("mid_we_seen", 32'(ram_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_we_drop", 32'(ram_we), 32'd0);
    check("mid_busy_drop", 32'(busy), 32'd0);
    repeat (2) begin
      @(negedge CLK_14M);
      check("mid_no_ack", 32'({doc_ack, host_ack}), 32'd0);
    end
    check("mid_no_write", 32'(mem[16'h2222]), 32'h11);
    reset_n = 1'b1;
    drain("mid_reset_retry");
    push_host(1'b0, 16'h2222, 8'h00);
    push_exp(1'b0, 8'h99);
    drain("mid_reset_readback");
    doc_q.push_back(16'h2222);
    push_exp(1'b1, 8'h99);
    drain("doc_readback");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sound_ram_arb.md
Name: sound_ram_arb

Overview:
- Arbitrates the single-port 64 KB sound RAM (syncram, one-cycle registered read) between two requesters.
- Requester one is the DOC sample-fetch path (es5503 addr_out during osc_en windows). Requester two is the host path (soundglu SNDDATA RAM reads/writes).
- DOC has fixed priority. A bounded-wait counter guarantees host forward progress.
- Sits inside the sound block, between soundglu/es5503 and syncram. It replaces the combinational osc_en address mux.

Parameters:
- HOST_MAX_WAIT, 8: number of cycles a pending host request may lose to DOC before it is forced ahead of DOC.
- WAIT_W, 4: width of the host wait counter. Must hold HOST_MAX_WAIT.

Ports:
- CLK_14M  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- doc_req  in  1  DOC fetch request; level, held until doc_ack
- doc_addr  in  16  DOC fetch address; stable while doc_req
- doc_ack  out  1  one-cycle pulse; doc_data valid this cycle
- doc_data  out  8  captured DOC read data; holds until next DOC completion
- host_req  in  1  host request; level, held until host_ack
- host_wr  in  1  1 = write, 0 = read; stable while host_req
- host_addr  in  16  host address; stable while host_req
- host_wdata  in  8  host write data
- host_ack  out  1  one-cycle pulse; completion of the host access
- host_rdata  out  8  captured host read data; holds until next host read completion
- ram_addr  out  16  syncram address
- ram_we  out  1  syncram write enable
- ram_wdata  out  8  syncram write data
- ram_rdata  in  8  syncram read data; valid the cycle after the address is presented
- busy  out  1  1 while an access is in flight (state != IDLE)

Behaviour:
- Reset values: state = IDLE; all outputs 0 (doc_ack, host_ack, doc_data, host_rdata, ram_addr, ram_we, ram_wdata, busy); wait_cnt = 0.
- Reset asserted mid-access aborts the access immediately. No ack is issued and ram_we drops asynchronously.
- States: IDLE, ACC_DOC, ACC_HOST, DONE_DOC, DONE_HOST.
- IDLE, grant decision, registered:
  - If host_req and wait_cnt >= HOST_MAX_WAIT, go to ACC_HOST. This is a forced grant.
  - Else if doc_req, go to ACC_DOC.
  - Else if host_req, go to ACC_HOST.
  - Else stay in IDLE.
- ACC_DOC (1 cycle):
  - ram_addr = doc_addr, ram_we = 0.
  - Next state DONE_DOC.
- ACC_HOST (1 cycle):
  - ram_addr = host_addr, ram_we = host_wr, ram_wdata = host_wdata.
  - Next state DONE_HOST.
- DONE_DOC (1 cycle): doc_data <= ram_rdata; doc_ack = 1; next state IDLE.
- DONE_HOST (1 cycle): if read, host_rdata <= ram_rdata; host_ack = 1; next state IDLE. For writes host_rdata is unchanged.
- ram_addr, ram_we and ram_wdata are registered outputs, asserted exactly during ACC_* cycles. ram_we is 0 in every other state.
- Timing: one access takes 3 cycles including IDLE arbitration.
  - Request seen in IDLE at cycle N gives address at N+1 and ack at N+2.
  - Maximum throughput is one access per 3 cycles.
- Acks are combinational from state DONE_*. The requester must drop or advance its req in the cycle after ack; the arbiter re-samples req in IDLE.
- wait_cnt:
  - Cleared on host grant or when host_req = 0.
  - Incremented (saturating at 2^WAIT_W - 1) each IDLE cycle in which host_req = 1 and DOC is granted.
- Simultaneous doc_req and host_req with wait_cnt < HOST_MAX_WAIT: DOC wins and wait_cnt increments.
- After a forced host grant, a pending DOC request is served at the next IDLE. No request is ever dropped.
- HOST_MAX_WAIT = 0: host always wins ties.
- A requester dropping req before ack is a protocol violation. The in-flight access still completes and acks.

Optional Feature:
- Macro SOUND_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_doc [15:0], stat_host [15:0] and stat_forced [7:0].
  - Each counts completed DOC accesses, completed host accesses and forced host grants respectively.
  - Counters wrap on overflow and reset to 0 on reset_n.
  - Adds input stat_clr, which synchronously zeroes all three counters. stat_clr wins over a same-cycle increment.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: hold reset_n = 0 with both reqs = 1 -> all outputs 0, no ram_we. Release -> DOC is granted first.
- DOC read: preload RAM[0x1234] = 0xA5; doc_req with doc_addr = 0x1234 -> ram_addr = 0x1234 one cycle after sampling, doc_ack pulse the next cycle with doc_data = 0xA5.
- Host write then read: host write 0x5A to 0xBEEF -> ram_we = 1 for exactly one cycle, host_ack. Host read of 0xBEEF -> host_rdata = 0x5A with host_ack.
- Contention: doc_req held permanently (re-asserted after each ack) with host_req held, HOST_MAX_WAIT = 8 -> exactly 8 DOC grants, then 1 forced host grant, then DOC resumes. No ack is lost.
- Reset mid-access: assert reset_n = 0 during ACC_HOST of a write -> ram_we drops immediately, no host_ack. After release the access is re-arbitrated.
- SOUND_ARB_STATS_EN: run the contention scenario for 20 completions -> stat_doc + stat_host = 20 and stat_forced = 2; then pulse stat_clr -> all counters 0.
